// File: rtl/vid_colour_bbox_if.sv
// Avalon-ST video sink and source signals of the colour bounding-box stage.
// A beat moves on any rising edge where valid && ready; the source holds data/sop/eop steady while valid && !ready.
interface vid_colour_bbox_if;
    logic [23:0] in_data;
    logic        in_valid;
    logic        in_sop;
    logic        in_eop;
    logic        in_ready;
    logic [23:0] out_data;
    logic        out_valid;
    logic        out_sop;
    logic        out_eop;
    logic        out_ready;

    modport slave (
        input  in_data, in_valid, in_sop, in_eop, out_ready,
        output in_ready, out_data, out_valid, out_sop, out_eop
    );

    modport master (
        output in_data, in_valid, in_sop, in_eop, out_ready,
        input  in_ready, out_data, out_valid, out_sop, out_eop
    );
endinterface

// File: rtl/vid_colour_bbox.sv
// RGB threshold match counter and per-frame bounding box tracker with one-register video pass-through
// and an outline overlay of the previously published box.
module vid_colour_bbox #(
    parameter int          IMAGE_W    = 640,
    parameter int          IMAGE_H    = 480,
    parameter int          MIN_PIXELS = 32,
    parameter logic [23:0] BOX_COLOUR = 24'hFF0000
) (
    input  logic                   clk,
    input  logic                   reset,
    vid_colour_bbox_if.slave       st,
    input  logic [23:0]            thr_lo,
    input  logic [23:0]            thr_hi,
    input  logic                   overlay_en,
    output logic [10:0]            bbox_left,
    output logic [10:0]            bbox_right,
    output logic [10:0]            bbox_top,
    output logic [10:0]            bbox_bottom,
    output logic [19:0]            match_count,
    output logic                   bbox_found,
    output logic                   frame_done,
    output logic                   frame_err,
    output logic [1:0]             fsm_state
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_VIDEO = 2'd1,
        S_CTRL  = 2'd2
    } state_t;

    localparam logic [10:0] X_LAST    = 11'(IMAGE_W - 1);
    localparam logic [10:0] COORD_MAX = 11'h7FF;
    localparam logic [21:0] FRAME_PIX = 22'(IMAGE_W * IMAGE_H);

    state_t      state;
    logic [10:0] x, y;
    logic [10:0] minx, maxx, miny, maxy;
    logic [19:0] cnt;
    logic [21:0] pix_cnt;
    logic [23:0] lo_q, hi_q;

    logic        accept, is_pix, match, on_outline;
    logic [10:0] minx_nx, maxx_nx, miny_nx, maxy_nx;
    logic [19:0] cnt_nx;
    logic [21:0] pix_nx;
    logic [23:0] pix_out;

    function automatic logic in_range(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    assign st.in_ready = st.out_ready || !st.out_valid;
    assign accept      = st.in_valid && st.in_ready;
    // The sop beat is the header; only non-sop beats inside a video packet are pixels.
    assign is_pix      = (state == S_VIDEO) && !st.in_sop;
    assign fsm_state   = state;

    always_comb begin
        match = in_range(st.in_data[23:16], lo_q[23:16], hi_q[23:16]) &&
                in_range(st.in_data[15:8],  lo_q[15:8],  hi_q[15:8])  &&
                in_range(st.in_data[7:0],   lo_q[7:0],   hi_q[7:0]);
        on_outline = ((x >= bbox_left) && (x <= bbox_right) && ((y == bbox_top) || (y == bbox_bottom))) ||
                     ((y >= bbox_top) && (y <= bbox_bottom) && ((x == bbox_left) || (x == bbox_right)));
        pix_out = st.in_data;
        if (overlay_en && bbox_found && is_pix && on_outline) begin
            pix_out = BOX_COLOUR;
        end
        cnt_nx  = cnt;
        minx_nx = minx;
        maxx_nx = maxx;
        miny_nx = miny;
        maxy_nx = maxy;
        if (match) begin
            if (cnt != 20'hFFFFF) cnt_nx = cnt + 20'd1;
            if (x < minx) minx_nx = x;
            if (x > maxx) maxx_nx = x;
            if (y < miny) miny_nx = y;
            if (y > maxy) maxy_nx = y;
        end
        pix_nx = (pix_cnt == 22'h3FFFFF) ? pix_cnt : pix_cnt + 22'd1;
    end

    always_ff @(posedge clk) begin
        frame_done <= 1'b0;
        if (reset) begin
            state        <= S_IDLE;
            st.out_valid <= 1'b0;
            st.out_data  <= '0;
            st.out_sop   <= 1'b0;
            st.out_eop   <= 1'b0;
            x            <= '0;
            y            <= '0;
            minx         <= COORD_MAX;
            miny         <= COORD_MAX;
            maxx         <= '0;
            maxy         <= '0;
            cnt          <= '0;
            pix_cnt      <= '0;
            lo_q         <= '0;
            hi_q         <= '0;
            bbox_left    <= COORD_MAX;
            bbox_top     <= COORD_MAX;
            bbox_right   <= '0;
            bbox_bottom  <= '0;
            match_count  <= '0;
            bbox_found   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            if (accept) begin
                st.out_valid <= 1'b1;
                st.out_data  <= pix_out;
                st.out_sop   <= st.in_sop;
                st.out_eop   <= st.in_eop;
            end else if (st.out_ready) begin
                st.out_valid <= 1'b0;
            end

            if (accept) begin
                if (st.in_sop) begin
                    x       <= '0;
                    y       <= '0;
                    minx    <= COORD_MAX;
                    miny    <= COORD_MAX;
                    maxx    <= '0;
                    maxy    <= '0;
                    cnt     <= '0;
                    pix_cnt <= '0;
                    lo_q    <= thr_lo;
                    hi_q    <= thr_hi;
                    if (st.in_eop)                   state <= S_IDLE;
                    else if (st.in_data[3:0] == 4'h0) state <= S_VIDEO;
                    else                              state <= S_CTRL;
                end else if (state == S_VIDEO) begin
                    cnt     <= cnt_nx;
                    minx    <= minx_nx;
                    maxx    <= maxx_nx;
                    miny    <= miny_nx;
                    maxy    <= maxy_nx;
                    pix_cnt <= pix_nx;
                    if (x == X_LAST) begin
                        x <= '0;
                        if (y != COORD_MAX) y <= y + 11'd1;
                    end else begin
                        x <= x + 11'd1;
                    end
                    if (st.in_eop) begin
                        state       <= S_IDLE;
                        match_count <= cnt_nx;
                        frame_err   <= (pix_nx != FRAME_PIX);
                        frame_done  <= 1'b1;
                        // A weak frame clears found but leaves the last good box in place.
                        if (cnt_nx >= 20'(MIN_PIXELS)) begin
                            bbox_left   <= minx_nx;
                            bbox_right  <= maxx_nx;
                            bbox_top    <= miny_nx;
                            bbox_bottom <= maxy_nx;
                            bbox_found  <= 1'b1;
                        end else begin
                            bbox_found  <= 1'b0;
                        end
                    end
                end else if ((state == S_CTRL) && st.in_eop) begin
                    state <= S_IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_vid_colour_bbox.sv
// Directed bench for vid_colour_bbox on a reduced 64x48 frame; a second instance runs with MIN_PIXELS=256.
module tb_vid_colour_bbox;
    localparam int W    = 64;
    localparam int H    = 48;
    localparam int NPIX = W * H;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vid_colour_bbox_if st();
    vid_colour_bbox_if st2();

    logic [23:0] thr_lo, thr_hi;
    logic        overlay_en;
    logic [10:0] bl, br, bt, bb, bl2, br2, bt2, bb2;
    logic [19:0] mc, mc2;
    logic        bf, fd, fe, bf2, fd2, fe2;
    logic [1:0]  fsm, fsm2;

    assign st2.in_data   = st.in_data;
    assign st2.in_valid  = st.in_valid;
    assign st2.in_sop    = st.in_sop;
    assign st2.in_eop    = st.in_eop;
    assign st2.out_ready = st.out_ready;

    vid_colour_bbox #(.IMAGE_W(W), .IMAGE_H(H), .MIN_PIXELS(32), .BOX_COLOUR(24'hFF0000)) dut (
        .clk(clk), .reset(reset), .st(st), .thr_lo(thr_lo), .thr_hi(thr_hi), .overlay_en(overlay_en),
        .bbox_left(bl), .bbox_right(br), .bbox_top(bt), .bbox_bottom(bb), .match_count(mc),
        .bbox_found(bf), .frame_done(fd), .frame_err(fe), .fsm_state(fsm)
    );

    vid_colour_bbox #(.IMAGE_W(W), .IMAGE_H(H), .MIN_PIXELS(256), .BOX_COLOUR(24'hFF0000)) dut2 (
        .clk(clk), .reset(reset), .st(st2), .thr_lo(thr_lo), .thr_hi(thr_hi), .overlay_en(overlay_en),
        .bbox_left(bl2), .bbox_right(br2), .bbox_top(bt2), .bbox_bottom(bb2), .match_count(mc2),
        .bbox_found(bf2), .frame_done(fd2), .frame_err(fe2), .fsm_state(fsm2)
    );

    int errors = 0;
    int checks = 0;
    int first_bad;
    logic [25:0] exp_q[$];
    logic [25:0] got_q[$];

    // Monitor: picks out_ready, records transferred beats, tracks held data during stalls.
    bit          bp_en = 1'b0;
    int          stall_viol = 0;
    int          done_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [25:0] prev_beat = '0;
    always @(negedge clk) begin
        st.out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (prev_stall && !(st.out_valid && ({st.out_sop, st.out_eop, st.out_data} == prev_beat)))
            stall_viol++;
        if (st.out_valid && st.out_ready) got_q.push_back({st.out_sop, st.out_eop, st.out_data});
        prev_stall = st.out_valid && !st.out_ready;
        prev_beat  = {st.out_sop, st.out_eop, st.out_data};
        if (fd === 1'b1) done_cnt++;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

    function automatic logic [23:0] pix(input int kind, input int x, input int y);
        if (kind == 0) return 24'h000000;
        if (kind == 1 && x >= 10 && x <= 29 && y >= 5 && y <= 14)
            return (x == 10) ? 24'h800000 : 24'hFF0000;
        if (x == 0 && y == 0) return 24'h7FFFFF;
        return {8'(x), 8'(y), 8'h55};
    endfunction

    function automatic bit outline(input int x, input int y);
        return (x >= 10 && x <= 29 && (y == 5 || y == 14)) || (y >= 5 && y <= 14 && (x == 10 || x == 29));
    endfunction

    function automatic int stream_diff();
        int n = 0;
        int m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        first_bad = -1;
        for (int i = 0; i < m; i++) begin
            if (got_q[i] !== exp_q[i]) begin
                n++;
                if (first_bad < 0) first_bad = i;
            end
        end
        n += (got_q.size() > exp_q.size()) ? got_q.size() - exp_q.size() : exp_q.size() - got_q.size();
        got_q.delete();
        exp_q.delete();
        return n;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [23:0] d, input logic s, input logic e, input logic [23:0] exp_d);
        bit ok = 1'b0;
        int guard = 0;
        st.in_data  = d;
        st.in_sop   = s;
        st.in_eop   = e;
        st.in_valid = 1'b1;
        while (!ok) begin
            ok = (st.in_ready === 1'b1);
            next_cycle();
            guard++;
            if (!ok && guard > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: beat %h not accepted after %0d cycles, want accepted", d, guard);
                ok = 1'b1;
            end
        end
        st.in_valid = 1'b0;
        exp_q.push_back({s, e, exp_d});
    endtask

    task automatic send_frame(input int kind, input int npix, input bit ovl, input bit mess_thr);
        logic [23:0] d, e;
        send_beat(24'h123450, 1'b1, 1'b0, 24'h123450);
        if (mess_thr) begin
            thr_lo = 24'h000000;
            thr_hi = 24'hFFFFFF;
        end
        for (int i = 0; i < npix; i++) begin
            d = pix(kind, i % W, i / W);
            e = (ovl && outline(i % W, i / W)) ? 24'hFF0000 : d;
            send_beat(d, 1'b0, i == npix - 1, e);
        end
    endtask

    task automatic drain();
        bp_en = 1'b0;
        for (int i = 0; i < 4; i++) next_cycle();
    endtask

    task automatic apply_reset();
        st.in_valid = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) next_cycle();
        reset = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (st.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", st.out_valid); end
        checks++; if (st.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", st.in_ready); end
        checks++; if ({st.out_sop, st.out_eop, st.out_data} !== 26'h0) begin errors++; $display("FAIL rst_out_reg: got %h want 0", {st.out_sop, st.out_eop, st.out_data}); end
        checks++; if ({bl, br, bt, bb} !== {11'd2047, 11'd0, 11'd2047, 11'd0}) begin errors++; $display("FAIL rst_bbox: got %0d %0d %0d %0d want 2047 0 2047 0", bl, br, bt, bb); end
        checks++; if (mc !== 20'd0) begin errors++; $display("FAIL rst_match_count: got %0d want 0", mc); end
        checks++; if ({bf, fd, fe} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b want 000", {bf, fd, fe}); end
        checks++; if (fsm !== 2'd0) begin errors++; $display("FAIL rst_fsm: got %0d want 0", fsm); end
        checks++; if ({fsm2, bf2, fd2, fe2} !== 5'b0) begin errors++; $display("FAIL rst_dut2: got %b want 00000", {fsm2, bf2, fd2, fe2}); end
    endtask

    task automatic test_black_frame();
        int n;
        thr_lo = 24'h800000;
        thr_hi = 24'hFFFFFF;
        overlay_en = 1'b0;
        send_frame(0, NPIX, 1'b0, 1'b0);
        checks++; if (fd !== 1'b1) begin errors++; $display("FAIL black_done: got %b want 1", fd); end
        checks++; if (mc !== 20'd0) begin errors++; $display("FAIL black_count: got %0d want 0", mc); end
        checks++; if ({bf, fe} !== 2'b00) begin errors++; $display("FAIL black_found_err: got %b want 00", {bf, fe}); end
        checks++; if ({bl, br, bt, bb} !== {11'd2047, 11'd0, 11'd2047, 11'd0}) begin errors++; $display("FAIL black_bbox: got %0d %0d %0d %0d want 2047 0 2047 0", bl, br, bt, bb); end
        next_cycle();
        checks++; if (fd !== 1'b0) begin errors++; $display("FAIL black_done_pulse: got %b want 0", fd); end
        drain();
        n = stream_diff();
        checks++; if (n != 0) begin errors++; $display("FAIL black_stream: got %0d bad beats (first %0d) want 0", n, first_bad); end
    endtask

    task automatic test_patch();
        int n;
        send_frame(1, NPIX, 1'b0, 1'b1);
        checks++; if (fd !== 1'b1) begin errors++; $display("FAIL patch_done: got %b want 1", fd); end
        checks++; if (mc !== 20'd200) begin errors++; $display("FAIL patch_count: got %0d want 200", mc); end
        checks++; if ({bl, br, bt, bb} !== {11'd10, 11'd29, 11'd5, 11'd14}) begin errors++; $display("FAIL patch_bbox: got %0d %0d %0d %0d want 10 29 5 14", bl, br, bt, bb); end
        checks++; if ({bf, fe} !== 2'b10) begin errors++; $display("FAIL patch_found_err: got %b want 10", {bf, fe}); end
        checks++; if ({fd2, mc2} !== {1'b1, 20'd200}) begin errors++; $display("FAIL min256_count: got done=%b cnt=%0d want done=1 cnt=200", fd2, mc2); end
        checks++; if (bf2 !== 1'b0) begin errors++; $display("FAIL min256_found: got %b want 0", bf2); end
        checks++; if ({bl2, br2, bt2, bb2} !== {11'd2047, 11'd0, 11'd2047, 11'd0}) begin errors++; $display("FAIL min256_bbox: got %0d %0d %0d %0d want 2047 0 2047 0", bl2, br2, bt2, bb2); end
        thr_lo = 24'h800000;
        thr_hi = 24'hFFFFFF;
        drain();
        n = stream_diff();
        checks++; if (n != 0) begin errors++; $display("FAIL patch_stream: got %0d bad beats (first %0d) want 0", n, first_bad); end
    endtask

    task automatic test_overlay();
        int n;
        overlay_en = 1'b1;
        send_frame(2, NPIX, 1'b1, 1'b0);
        checks++; if ({fd, mc, bf} !== {1'b1, 20'd0, 1'b0}) begin errors++; $display("FAIL ovl_result: got done=%b cnt=%0d found=%b want 1 0 0", fd, mc, bf); end
        checks++; if ({bl, br, bt, bb} !== {11'd10, 11'd29, 11'd5, 11'd14}) begin errors++; $display("FAIL ovl_bbox_kept: got %0d %0d %0d %0d want 10 29 5 14", bl, br, bt, bb); end
        drain();
        overlay_en = 1'b0;
        n = stream_diff();
        checks++; if (n != 0) begin errors++; $display("FAIL ovl_stream: got %0d bad beats (first %0d) want 0", n, first_bad); end
    endtask

    task automatic test_back_to_back();
        int n;
        bp_en = 1'b1;
        send_frame(1, NPIX, 1'b0, 1'b0);
        checks++; if ({fd, mc, bf, fe} !== {1'b1, 20'd200, 1'b1, 1'b0}) begin errors++; $display("FAIL bp_result: got done=%b cnt=%0d found=%b err=%b want 1 200 1 0", fd, mc, bf, fe); end
        drain();
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_hold: got %0d unstable stalls want 0", stall_viol); end
        n = stream_diff();
        checks++; if (n != 0) begin errors++; $display("FAIL bp_stream: got %0d bad beats (first %0d) want 0", n, first_bad); end
    endtask

    task automatic test_ctrl_and_short();
        int n;
        int base = done_cnt;
        send_beat(24'h00000F, 1'b1, 1'b0, 24'h00000F);
        checks++; if (fsm !== 2'd2) begin errors++; $display("FAIL ctrl_fsm: got %0d want 2", fsm); end
        send_beat(24'hFF0000, 1'b0, 1'b0, 24'hFF0000);
        send_beat(24'hC0FFEE, 1'b0, 1'b0, 24'hC0FFEE);
        send_beat(24'hFF0000, 1'b0, 1'b1, 24'hFF0000);
        send_beat(24'h0000AA, 1'b0, 1'b0, 24'h0000AA);
        checks++; if (fsm !== 2'd0) begin errors++; $display("FAIL ctrl_idle: got %0d want 0", fsm); end
        drain();
        checks++; if (done_cnt != base) begin errors++; $display("FAIL ctrl_no_done: got %0d pulses want 0", done_cnt - base); end
        checks++; if (mc !== 20'd200) begin errors++; $display("FAIL ctrl_count_kept: got %0d want 200", mc); end
        n = stream_diff();
        checks++; if (n != 0) begin errors++; $display("FAIL ctrl_stream: got %0d bad beats (first %0d) want 0", n, first_bad); end
        send_frame(1, 1000, 1'b0, 1'b0);
        checks++; if ({fd, fe} !== 2'b11) begin errors++; $display("FAIL short_err: got done=%b err=%b want 1 1", fd, fe); end
        checks++; if ({mc, bf} !== {20'd200, 1'b1}) begin errors++; $display("FAIL short_count: got %0d found=%b want 200 1", mc, bf); end
        drain();
        n = stream_diff();
        checks++; if (n != 0) begin errors++; $display("FAIL short_stream: got %0d bad beats (first %0d) want 0", n, first_bad); end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        int base;
        send_beat(24'h123450, 1'b1, 1'b0, 24'h123450);
        for (int i = 0; i < 1000; i++) send_beat(pix(1, i % W, i / W), 1'b0, 1'b0, pix(1, i % W, i / W));
        base = done_cnt;
        apply_reset();
        checks++; if ({st.out_valid, fsm} !== 3'b000) begin errors++; $display("FAIL midrst_state: got valid=%b fsm=%0d want 0 0", st.out_valid, fsm); end
        checks++; if ({mc, bf, bl} !== {20'd0, 1'b0, 11'd2047}) begin errors++; $display("FAIL midrst_results: got cnt=%0d found=%b left=%0d want 0 0 2047", mc, bf, bl); end
        got_q.delete();
        exp_q.delete();
        send_frame(1, NPIX, 1'b0, 1'b0);
        checks++; if ({fd, mc, bf, fe} !== {1'b1, 20'd200, 1'b1, 1'b0}) begin errors++; $display("FAIL clean_result: got done=%b cnt=%0d found=%b err=%b want 1 200 1 0", fd, mc, bf, fe); end
        checks++; if ({bl, br, bt, bb} !== {11'd10, 11'd29, 11'd5, 11'd14}) begin errors++; $display("FAIL clean_bbox: got %0d %0d %0d %0d want 10 29 5 14", bl, br, bt, bb); end
        drain();
        checks++; if (done_cnt != base + 1) begin errors++; $display("FAIL clean_one_done: got %0d pulses want 1", done_cnt - base); end
        n = stream_diff();
        checks++; if (n != 0) begin errors++; $display("FAIL clean_stream: got %0d bad beats (first %0d) want 0", n, first_bad); end
    endtask

    initial begin
        reset       = 1'b1;
        st.in_valid = 1'b0;
        st.in_data  = '0;
        st.in_sop   = 1'b0;
        st.in_eop   = 1'b0;
        thr_lo      = 24'h800000;
        thr_hi      = 24'hFFFFFF;
        overlay_en  = 1'b0;
        @(negedge clk);
        #1;
        test_reset();
        test_black_frame();
        test_patch();
        test_overlay();
        test_back_to_back();
        test_ctrl_and_short();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vid_colour_bbox.md
Name: vid_colour_bbox

Overview:
- Avalon-ST video stage between the frame-buffer reader and the clocked-video output (ITC).
- Passes 24-bit RGB video through with one register stage.
- Counts pixels whose RGB lies inside a programmable threshold box and tracks their bounding box per frame.
- Draws the previous frame's box as a 1-pixel outline on the outgoing video; publishes results at end of frame for the Nios/UART reporting path.

Parameters:
- IMAGE_W, 640, active pixels per line
- IMAGE_H, 480, active lines per frame
- MIN_PIXELS, 32, minimum matching-pixel count for a box to be reported as found
- BOX_COLOUR, 24'hFF0000, RGB written on outline pixels

Ports:
- clk  in  1  single clock for all logic
- reset  in  1  synchronous, active-high
- in_data  in  24  RGB pixel {R[23:16],G[15:8],B[7:0]}
- in_valid  in  1  sink valid
- in_sop  in  1  start of packet
- in_eop  in  1  end of packet
- in_ready  out  1  sink ready
- out_data  out  24  source pixel
- out_valid  out  1  source valid
- out_sop  out  1  source start of packet
- out_eop  out  1  source end of packet
- out_ready  in  1  source ready
- thr_lo  in  24  per-channel inclusive lower RGB bounds
- thr_hi  in  24  per-channel inclusive upper RGB bounds
- overlay_en  in  1  enable outline drawing
- bbox_left, bbox_right  out  11  x bounds of last completed frame
- bbox_top, bbox_bottom  out  11  y bounds of last completed frame
- match_count  out  20  matching pixels in last completed frame
- bbox_found  out  1  match_count >= MIN_PIXELS for last frame
- frame_done  out  1  one-cycle pulse when results update
- frame_err  out  1  last video packet length != IMAGE_W*IMAGE_H

Behaviour:
- Handshakes:
  - A beat transfers when valid && ready.
  - in_ready = out_ready || !out_valid (single output register, no combinational valid path).
  - Output holds data, sop and eop stable while out_valid && !out_ready.
- Latency: 1 cycle from accepted input beat to out_valid.
- Packet FSM: IDLE -> HDR on accepted in_sop beat; the header beat is in_data[3:0].
  - Type 0 -> VIDEO; any other type -> CTRL. Header beat is always forwarded unchanged.
  - VIDEO/CTRL -> IDLE on accepted in_eop beat. A header beat carrying eop also returns to IDLE.
  - An in_sop beat in any state restarts at the header (previous packet abandoned; results not published).
  - Beats in IDLE without sop are forwarded unchanged and ignored by statistics.
- Coordinates:
  - x, y clear at header.
  - Each accepted VIDEO pixel: x++. At x == IMAGE_W-1, x wraps to 0 and y++. y saturates at 2047.
- Match rule: each channel satisfies thr_lo <= ch <= thr_hi, unsigned. thr_lo/thr_hi are sampled at the header beat and held for the frame.
- Accumulators, cleared at header:
  - minx/miny reset to 2047, maxx/maxy to 0.
  - cnt saturates at 2^20-1.
- At the VIDEO eop beat (one cycle after acceptance):
  - Latch cnt into match_count.
  - If cnt >= MIN_PIXELS: latch bbox_* from min/max and set bbox_found=1.
  - Otherwise: bbox_found=0 and bbox_* keep their previous values.
  - frame_err=1 iff pixels accepted != IMAGE_W*IMAGE_H.
  - Pulse frame_done.
  - CTRL packets never publish.
- Overlay: when overlay_en && bbox_found, an outgoing VIDEO pixel is replaced by BOX_COLOUR if any of:
  - x in [bbox_left, bbox_right] and y == bbox_top or y == bbox_bottom
  - y in [bbox_top, bbox_bottom] and x == bbox_left or x == bbox_right
  - The overlay uses the published box, i.e. the previous frame's.
- Results change only on frame_done; overlay in frame N uses box of frame N-1 even if a frame N result publishes at eop.
- Reset values:
  - out_valid=0, in_ready=1, out_data/sop/eop=0.
  - bbox_left=bbox_top=2047, bbox_right=bbox_bottom=0.
  - match_count=0, bbox_found=0, frame_done=0, frame_err=0.
  - FSM IDLE.
- Reset mid-frame: the partial frame is discarded and the output register is dropped. Statistics resume at the next sop.

Test Plan:
- Reset, then 640x480 black frame with thr_lo=0x800000, thr_hi=0xFFFFFF -> frame_done one cycle after eop; match_count=0, bbox_found=0, frame_err=0, bbox regs at reset values.
- 640x480 frame with red (0xFF0000) 20x10 patch at x=100..119, y=50..59 -> match_count=200, bbox=(100,119,50,59), bbox_found=1; next frame with overlay_en=1 outputs 0xFF0000 exactly on the outline pixels, all other pixels unchanged.
- Same patch with MIN_PIXELS raised to 256 -> bbox_found=0, bbox regs unchanged from previous frame, match_count=200.
- Random out_ready backpressure (50%) over a full frame -> output pixel stream identical to the input, no beat lost or duplicated, held data stable while stalled.
- Control packet (header 0xF, 4 beats) between frames -> forwarded unchanged, no frame_done; short video frame of 1000 pixels -> frame_done with frame_err=1.
- Assert reset at pixel 5000 of a frame, then a full clean frame -> first frame_done corresponds to the clean frame only, with correct counts.
